serial_adder: RTL

Parametrised multi-cycle adder/subtractor: the next generation of the single-bit full adder. It processes WIDTH-bit operands DIGIT bits per clock through a registered carry chain and signals completion with a one-cycle done pulse. It serves datapaths that trade latency for area: one DIGIT-wide adder slice is reused over WIDTH/DIGIT cycles instead of building a full WIDTH-bit ripple adder.

---
 rtl/serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice reused over
// WIDTH/DIGIT cycles, with a registered carry between chunks.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad
    $error("serial_adder: DIGIT must divide WIDTH");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT-1:0] ds;
  logic [DIGIT:0]   dsum;
  logic             dc;
  logic             dm;
  logic [WIDTH-1:0] r_nxt;
  logic             last;
  logic             take;

  always_comb begin
    da    = a_sr[DIGIT-1:0];
    db    = b_sr[DIGIT-1:0];
    dsum  = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, cy};
    ds    = dsum[DIGIT-1:0];
    dc    = dsum[DIGIT];
    // carry into the top bit of this chunk, recovered from its sum bit
    dm    = da[DIGIT-1] ^ db[DIGIT-1] ^ ds[DIGIT-1];
    r_nxt = (r_sr >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
    last  = (cnt == CW'(N - 1));
    take  = start && (state != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (take) begin
        a_sr <= A;
        b_sr <= B ^ {WIDTH{Sub}};
        cy   <= Sub | Cin;
        r_sr <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> DIGIT;
        b_sr <= b_sr >> DIGIT;
        cy   <= dc;
        r_sr <= r_nxt;
        cnt  <= cnt + CW'(1);
      end

      unique case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          busy  <= take;
          state <= take ? RUN : IDLE;
        end
        RUN: begin
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            Sum      <= r_nxt;
            Cout     <= dc;
            Overflow <= dm ^ dc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
